// File: rtl/sbox_drv_pkg.sv
// -----------------------------------------------------------------------------
// sbox_drv_pkg
//
// Shared definitions for the masked Skinny S-box driver:
//   - FSM state encoding of the driver,
//   - share-count / mask-width / Fresh-width helpers (usable with any masking
//     order) plus the values for the default configuration,
//   - the unprotected Skinny 4-bit S-box table, used by reference models.
// -----------------------------------------------------------------------------
package sbox_drv_pkg;

    // Default configuration of the driven S-box.
    localparam int DEF_SEC_ORDER = 3;
    localparam int DEF_N_GADGETS = 21;
    localparam int DEF_TIMEOUT   = 32;

    // Driver FSM.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_START   = 3'd1,
        ST_WAIT    = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_HOLD    = 3'd4
    } drv_state_t;

    // Number of Boolean shares for masking order d.
    function automatic int shares_of(input int sec_order);
        return sec_order + 1;
    endfunction

    // Width of the random mask shares s1..sd.
    function automatic int mask_w_of(input int sec_order);
        return 4 * sec_order;
    endfunction

    // Every HPC2 gadget consumes d*(d+1)/2 fresh bits per cycle.
    function automatic int fresh_w_of(input int sec_order, input int n_gadgets);
        return n_gadgets * sec_order * (sec_order + 1) / 2;
    endfunction

    localparam int SHARES  = shares_of(DEF_SEC_ORDER);
    localparam int MASK_W  = mask_w_of(DEF_SEC_ORDER);
    localparam int FRESH_W = fresh_w_of(DEF_SEC_ORDER, DEF_N_GADGETS);

    // Unprotected Skinny-64 S-box.
    function automatic logic [3:0] skinny_sbox(input logic [3:0] x);
        logic [3:0] y;
        y = 4'h0;
        case (x)
            4'h0: y = 4'hC;
            4'h1: y = 4'h6;
            4'h2: y = 4'h9;
            4'h3: y = 4'h0;
            4'h4: y = 4'h1;
            4'h5: y = 4'hA;
            4'h6: y = 4'h2;
            4'h7: y = 4'hB;
            4'h8: y = 4'h3;
            4'h9: y = 4'h8;
            4'hA: y = 4'h5;
            4'hB: y = 4'hD;
            4'hC: y = 4'h4;
            4'hD: y = 4'hE;
            4'hE: y = 4'h7;
            default: y = 4'hF;
        endcase
        return y;
    endfunction

endpackage

// File: rtl/sbox_masked_driver_if.sv
// -----------------------------------------------------------------------------
// sbox_masked_driver_if
//
// Bundles every non-clock signal of the masked S-box driver:
//   in_*      : unmasked nibble input handshake (valid/ready)
//   rnd       : per-cycle randomness (low MASK bits = mask shares, rest = Fresh)
//   sbox_*    : connection to the gated-clock masked S-box (rst, shares,
//               Fresh, output shares, Synch strobe)
//   out_*     : result handshake carrying output shares and recombined nibble
//   err_timeout : sticky "Synch never arrived" flag
//
// Modports:
//   slave  - the driver itself
//   master - the environment (stimulus source, S-box, result sink)
// -----------------------------------------------------------------------------
interface sbox_masked_driver_if #(
    parameter int SEC_ORDER = 3,
    parameter int N_GADGETS = 21
);
    import sbox_drv_pkg::*;

    localparam int NUM_SHARES = shares_of(SEC_ORDER);
    localparam int MASK_BITS  = mask_w_of(SEC_ORDER);
    localparam int FRESH_BITS = fresh_w_of(SEC_ORDER, N_GADGETS);

    logic                          in_valid;
    logic                          in_ready;
    logic [3:0]                    in_data;
    logic [MASK_BITS+FRESH_BITS-1:0] rnd;
    logic                          sbox_rst;
    logic [4*NUM_SHARES-1:0]       sbox_si;
    logic [FRESH_BITS-1:0]         sbox_fresh;
    logic [4*NUM_SHARES-1:0]       sbox_so;
    logic                          sbox_synch;
    logic                          out_valid;
    logic                          out_ready;
    logic [4*NUM_SHARES-1:0]       out_shares;
    logic [3:0]                    out_data;
    logic                          err_timeout;

    modport slave (
        input  in_valid,
        output in_ready,
        input  in_data,
        input  rnd,
        output sbox_rst,
        output sbox_si,
        output sbox_fresh,
        input  sbox_so,
        input  sbox_synch,
        output out_valid,
        input  out_ready,
        output out_shares,
        output out_data,
        output err_timeout
    );

    modport master (
        output in_valid,
        input  in_ready,
        output in_data,
        output rnd,
        input  sbox_rst,
        input  sbox_si,
        input  sbox_fresh,
        output sbox_so,
        output sbox_synch,
        input  out_valid,
        output out_ready,
        input  out_shares,
        input  out_data,
        input  err_timeout
    );

endinterface

// File: rtl/sbox_masked_driver_share_split.sv
// -----------------------------------------------------------------------------
// share_split
//
// Combinational Boolean masking of one nibble into SEC_ORDER+1 shares.
//   data   in  4               nibble to mask
//   mask   in  4*SEC_ORDER     random shares s1..sd (s_i at [4(i-1)+3:4(i-1)])
//   shares out 4*(SEC_ORDER+1) share i at [4i+3:4i]; s0 = data ^ s1 ^ ... ^ sd
//
// The same XOR chain also recombines a share vector: feeding s0 as data and
// s1..sd as mask yields the unmasked value in shares[3:0].
// -----------------------------------------------------------------------------
module share_split #(
    parameter int SEC_ORDER = 3
) (
    input  logic [3:0]                 data,
    input  logic [4*SEC_ORDER-1:0]     mask,
    output logic [4*(SEC_ORDER+1)-1:0] shares
);
    import sbox_drv_pkg::*;

    localparam int NUM_SHARES = shares_of(SEC_ORDER);

    // acc[i] = data ^ s1 ^ ... ^ si
    logic [SEC_ORDER:0][3:0] acc;

    assign acc[0] = data;

    generate
        for (genvar gi = 0; gi < SEC_ORDER; gi++) begin : g_mask
            assign acc[gi+1]              = acc[gi] ^ mask[4*gi +: 4];
            assign shares[4*(gi+1) +: 4]  = mask[4*gi +: 4];
        end
    endgenerate

    assign shares[3:0] = acc[NUM_SHARES-1];

endmodule

// File: rtl/sbox_masked_driver.sv
// -----------------------------------------------------------------------------
// sbox_masked_driver
//
// Initiator side of the masked Skinny S-box Synch interface.
// Accepts an unmasked nibble, splits it into SEC_ORDER+1 shares, kicks the
// gated-clock S-box with a one-cycle sbox_rst, waits (bounded by TIMEOUT) for
// sbox_synch, captures the output shares and returns them together with their
// recombination.
//
// Ports:
//   clk  : system clock (also clocks the S-box)
//   rst  : synchronous active-high reset
//   bus  : sbox_masked_driver_if.slave
//          in_valid/in_ready/in_data      - input nibble handshake
//          rnd                            - per-cycle randomness
//          sbox_rst/sbox_si/sbox_fresh    - to the S-box
//          sbox_so/sbox_synch             - from the S-box
//          out_valid/out_ready/out_shares/out_data - result handshake
//          err_timeout                    - sticky Synch timeout flag
// -----------------------------------------------------------------------------
module sbox_masked_driver #(
    parameter int SEC_ORDER = sbox_drv_pkg::DEF_SEC_ORDER,
    parameter int N_GADGETS = sbox_drv_pkg::DEF_N_GADGETS,
    parameter int TIMEOUT   = sbox_drv_pkg::DEF_TIMEOUT
) (
    input  logic                 clk,
    input  logic                 rst,
    sbox_masked_driver_if.slave  bus
);
    import sbox_drv_pkg::*;

    localparam int NUM_SHARES = shares_of(SEC_ORDER);
    localparam int MASK_BITS  = mask_w_of(SEC_ORDER);
    localparam int FRESH_BITS = fresh_w_of(SEC_ORDER, N_GADGETS);
    localparam int SH_W       = 4 * NUM_SHARES;
    localparam int CNT_W      = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    drv_state_t        state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic [SH_W-1:0]   si_reg, si_next;
    logic [SH_W-1:0]   out_shares_reg, out_shares_next;
    logic [3:0]        out_data_reg, out_data_next;
    logic              err_reg, err_next;
    logic              sbox_rst_reg, sbox_rst_next;

    logic [SH_W-1:0]   split_shares;
    logic [SH_W-1:0]   rec_shares;

    // ------------------------------------------------------------------
    // Input masking: s1..sd come straight from the mask part of rnd.
    // ------------------------------------------------------------------
    share_split #(
        .SEC_ORDER (SEC_ORDER)
    ) u_split (
        .data   (bus.in_data),
        .mask   (bus.rnd[MASK_BITS-1:0]),
        .shares (split_shares)
    );

    // ------------------------------------------------------------------
    // Output recombination, kept next to the output register so that the
    // unmasked value exists nowhere else. rec_shares[3:0] is the XOR of all
    // S-box output shares; the upper lanes just echo s1..sd of sbox_so.
    // ------------------------------------------------------------------
    share_split #(
        .SEC_ORDER (SEC_ORDER)
    ) u_recombine (
        .data   (bus.sbox_so[3:0]),
        .mask   (bus.sbox_so[SH_W-1:4]),
        .shares (rec_shares)
    );

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            cnt_reg        <= '0;
            si_reg         <= '0;
            out_shares_reg <= '0;
            out_data_reg   <= '0;
            err_reg        <= 1'b0;
            // Keep the S-box controller in reset while we are.
            sbox_rst_reg   <= 1'b1;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            si_reg         <= si_next;
            out_shares_reg <= out_shares_next;
            out_data_reg   <= out_data_next;
            err_reg        <= err_next;
            sbox_rst_reg   <= sbox_rst_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next      = state_reg;
        cnt_next        = cnt_reg;
        si_next         = si_reg;
        out_shares_next = out_shares_reg;
        out_data_next   = out_data_reg;
        err_next        = err_reg;
        sbox_rst_next   = 1'b0;

        unique case (state_reg)
            ST_IDLE: begin
                // in_ready is 1 in IDLE, so in_valid alone is the accept.
                if (bus.in_valid) begin
                    si_next       = split_shares;
                    sbox_rst_next = 1'b1;   // registered: high only during START
                    state_next    = ST_START;
                end
            end

            ST_START: begin
                cnt_next   = '0;
                state_next = ST_WAIT;
            end

            ST_WAIT: begin
                // Synch wins over the timeout when both land on the same edge.
                if (bus.sbox_synch) begin
                    state_next = ST_CAPTURE;
                end else if (cnt_reg == CNT_LAST) begin
                    err_next   = 1'b1;
                    state_next = ST_IDLE;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end

            ST_CAPTURE: begin
                // The S-box output register was loaded on the edge that
                // coincided with Synch, so sbox_so is settled here.
                out_shares_next = {rec_shares[SH_W-1:4], bus.sbox_so[3:0]};
                out_data_next   = rec_shares[3:0];
                state_next      = ST_HOLD;
            end

            ST_HOLD: begin
                if (bus.out_ready) begin
                    state_next = ST_IDLE;
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.in_ready    = (state_reg == ST_IDLE);
    assign bus.out_valid   = (state_reg == ST_HOLD);
    assign bus.sbox_rst    = sbox_rst_reg;
    assign bus.sbox_si     = si_reg;
    // Gadgets need new randomness every cycle: pass-through, never registered.
    assign bus.sbox_fresh  = bus.rnd[MASK_BITS +: FRESH_BITS];
    assign bus.out_shares  = out_shares_reg;
    assign bus.out_data    = out_data_reg;
    assign bus.err_timeout = err_reg;

endmodule

// File: tb/tb_sbox_masked_driver.sv
// -----------------------------------------------------------------------------
// tb_sbox_masked_driver
//
// Directed bench for sbox_masked_driver with a behavioural masked S-box:
// on sbox_rst it starts counting and raises sbox_synch m_lat cycles later,
// loading remasked Skinny output shares on the edge that starts Synch.
// -----------------------------------------------------------------------------
module tb_sbox_masked_driver;
    import sbox_drv_pkg::*;

    localparam int SEC_ORDER = DEF_SEC_ORDER;
    localparam int RND_W     = MASK_W + FRESH_W;
    localparam int SH_W      = 4 * SHARES;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    sbox_masked_driver_if #(.SEC_ORDER(SEC_ORDER), .N_GADGETS(DEF_N_GADGETS)) bus ();

    sbox_masked_driver #(
        .SEC_ORDER (SEC_ORDER),
        .N_GADGETS (DEF_N_GADGETS),
        .TIMEOUT   (DEF_TIMEOUT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Expected Skinny outputs, written out independently of the package.
    logic [3:0] exp_sbox [16] = '{4'hC, 4'h6, 4'h9, 4'h0, 4'h1, 4'hA, 4'h2, 4'hB,
                                  4'h3, 4'h8, 4'h5, 4'hD, 4'h4, 4'hE, 4'h7, 4'hF};

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural masked S-box
    // ------------------------------------------------------------------
    logic [7:0]        m_cnt    = '0;
    logic              m_run    = 1'b0;
    int                m_lat    = 9;
    logic              synch_en = 1'b1;
    logic [MASK_W-1:0] so_mask  = '0;
    logic [SH_W-1:0]   m_so     = '0;

    function automatic logic [SH_W-1:0] model_out(input logic [SH_W-1:0] si,
                                                  input logic [MASK_W-1:0] r);
        logic [3:0] x;
        logic [3:0] y;
        x = '0;
        for (int i = 0; i < SHARES; i++) x ^= si[4*i +: 4];
        y = skinny_sbox(x);
        for (int i = 0; i < SEC_ORDER; i++) y ^= r[4*i +: 4];
        return {r, y};
    endfunction

    always @(posedge clk) begin
        if (bus.sbox_rst) begin
            m_run <= 1'b1;
            m_cnt <= 8'd1;
        end else if (m_run) begin
            m_cnt <= m_cnt + 8'd1;
            if (m_cnt == 8'(m_lat - 1)) m_so <= model_out(bus.sbox_si, so_mask);
            if (m_cnt == 8'(m_lat))     m_run <= 1'b0;
        end
    end

    assign bus.sbox_so    = m_so;
    assign bus.sbox_synch = synch_en & m_run & (m_cnt == 8'(m_lat));

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    bit rnd_mode = 1'b0;

    function automatic logic [RND_W-1:0] rand_rnd();
        logic [RND_W-1:0] v;
        v = '0;
        for (int i = 0; i < (RND_W + 31) / 32; i++) v = {v[RND_W-33:0], $urandom()};
        return v;
    endfunction

    // Advance one clock; new randomness after the edge, sample 2 ns later.
    task automatic tick();
        @(posedge clk);
        #1;
        if (rnd_mode) bus.rnd = rand_rnd();
        #1;
    endtask

    task automatic run_txn(input logic [3:0] din, input int lat, input int hold, input bit rand_mask);
        logic [RND_W-1:0] r_acc;
        logic [SH_W-1:0]  exp_si;
        logic [3:0]       x;
        int               k;
        int               rst_pulses;

        m_lat   = lat;
        so_mask = rand_mask ? MASK_W'($urandom()) : '0;
        check("idle_in_ready", bus.in_ready, 1'b1);

        bus.in_valid = 1'b1;
        bus.in_data  = din;
        r_acc        = bus.rnd;
        tick();
        bus.in_valid = 1'b0;

        exp_si[SH_W-1:4] = r_acc[MASK_W-1:0];
        x = din;
        for (int i = 0; i < SEC_ORDER; i++) x ^= r_acc[4*i +: 4];
        exp_si[3:0] = x;
        check("sbox_si", bus.sbox_si, exp_si);
        x = '0;
        for (int i = 0; i < SHARES; i++) x ^= bus.sbox_si[4*i +: 4];
        check("si_xor", x, din);
        check("busy_in_ready", bus.in_ready, 1'b0);
        rst_pulses = bus.sbox_rst ? 1 : 0;

        k = 0;
        while (!bus.out_valid && k < 60) begin
            tick();
            k++;
            if (bus.sbox_rst) rst_pulses++;
            if (k <= lat) check("fresh", bus.sbox_fresh, bus.rnd[MASK_W +: FRESH_W]);
        end
        check("latency", k, lat + 2);
        check("out_data", bus.out_data, exp_sbox[din]);
        check("out_shares", bus.out_shares, m_so);
        x = '0;
        for (int i = 0; i < SHARES; i++) x ^= bus.out_shares[4*i +: 4];
        check("out_xor", x, exp_sbox[din]);

        // Back-pressure with a competing request that must not be taken.
        if (hold > 0) begin
            bus.in_valid = 1'b1;
            bus.in_data  = ~din;
        end
        for (int i = 0; i < hold; i++) begin
            tick();
            if (bus.sbox_rst) rst_pulses++;
            check("hold_valid", bus.out_valid, 1'b1);
            check("hold_data", bus.out_data, exp_sbox[din]);
            check("hold_shares", bus.out_shares, m_so);
            check("hold_in_ready", bus.in_ready, 1'b0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check("release_valid", bus.out_valid, 1'b0);
        check("release_in_ready", bus.in_ready, 1'b1);
        check("sbox_rst_pulses", rst_pulses, 1);
        $display("TXN din=%h lat=%0d hold=%0d out_data=%h out_shares=%h cycles=%0d",
                 din, lat, hold, bus.out_data, bus.out_shares, k);
    endtask

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    initial begin
        int  k;
        bit  saw;

        bus.in_valid  = 1'b0;
        bus.in_data   = 4'h0;
        bus.rnd       = '0;
        bus.out_ready = 1'b0;

        // Reset state
        repeat (2) tick();
        check("rst_in_ready", bus.in_ready, 1'b1);
        check("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_err", bus.err_timeout, 1'b0);
        check("rst_sbox_rst", bus.sbox_rst, 1'b1);
        check("rst_sbox_si", bus.sbox_si, '0);
        check("rst_out_shares", bus.out_shares, '0);
        check("rst_out_data", bus.out_data, 4'h0);
        rst = 1'b0;
        tick();
        check("idle_sbox_rst", bus.sbox_rst, 1'b0);
        $display("TXN reset done");

        // All-zero randomness, nominal latency, 20 cycles of back-pressure
        run_txn(4'h0, 9, 20, 1'b0);
        check("zero_rnd_shares", bus.out_shares, 16'h000C);

        // Full input sweep with random masks and Fresh
        rnd_mode = 1'b1;
        for (int v = 0; v < 16; v++) run_txn(4'(v), 9, 0, 1'b1);

        // Synch on the very last allowed cycle still succeeds
        run_txn(4'hA, DEF_TIMEOUT, 0, 1'b1);
        check("boundary_no_err", bus.err_timeout, 1'b0);

        // Synch never comes
        synch_en     = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = 4'h5;
        tick();
        bus.in_valid = 1'b0;
        k   = 0;
        saw = 1'b0;
        while (!bus.err_timeout && k < 60) begin
            tick();
            k++;
            if (bus.out_valid) saw = 1'b1;
        end
        // one START cycle plus TIMEOUT cycles of WAIT
        check("timeout_cycles", k, DEF_TIMEOUT + 1);
        check("timeout_in_ready", bus.in_ready, 1'b1);
        check("timeout_no_valid", saw, 1'b0);
        $display("TXN timeout din=5 cycles=%0d err=%0b", k, bus.err_timeout);
        synch_en = 1'b1;

        // Good transaction afterwards; error stays sticky
        run_txn(4'h7, 9, 0, 1'b1);
        check("err_sticky", bus.err_timeout, 1'b1);

        // Reset in the middle of WAIT
        bus.in_valid = 1'b1;
        bus.in_data  = 4'h3;
        tick();
        bus.in_valid = 1'b0;
        repeat (4) tick();
        rst = 1'b1;
        tick();
        check("abort_in_ready", bus.in_ready, 1'b1);
        check("abort_out_valid", bus.out_valid, 1'b0);
        check("abort_sbox_rst", bus.sbox_rst, 1'b1);
        check("abort_err_cleared", bus.err_timeout, 1'b0);
        check("abort_sbox_si", bus.sbox_si, '0);
        rst = 1'b0;
        saw = 1'b0;
        repeat (20) begin
            tick();
            if (bus.out_valid) saw = 1'b1;
        end
        check("late_synch_no_valid", saw, 1'b0);
        check("late_synch_in_ready", bus.in_ready, 1'b1);
        $display("TXN abort din=3 out_valid_seen=%0b", saw);

        // Recovery after the abort
        run_txn(4'hD, 9, 0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog obs=running exp=finished");
        $fatal(1);
    end

endmodule

// File: doc/sbox_masked_driver.md
Name: sbox_masked_driver

Overview:
- Initiator/consumer side of the masked Skinny S-box Synch interface.
- Accepts an unmasked 4-bit nibble over valid/ready and splits it into SEC_ORDER+1 Boolean shares.
- Drives the masked S-box (shares, Fresh, rst), waits for its Synch and captures the output shares.
- Returns the shares and the recombined result over valid/ready. Used as a test and integration harness around the gated-clock masked S-box.

Parameters:
- SEC_ORDER, 3, masking order d; share count = d+1.
- N_GADGETS, 21, HPC2 gadget count in the driven S-box.
- FRESH_W, N_GADGETS*SEC_ORDER*(SEC_ORDER+1)/2 (=126), width of the Fresh bus.
- TIMEOUT, 32, maximum cycles to wait for sbox_synch before raising an error.

Ports:
- clk  in  1  system clock; also clocks the S-box.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input nibble valid.
- in_ready  out  1  driver can accept a nibble.
- in_data  in  4  unmasked S-box input.
- rnd  in  4*SEC_ORDER+FRESH_W  fresh randomness, new every cycle. Low 4*SEC_ORDER bits are mask shares; upper bits are Fresh.
- sbox_rst  out  1  reset/start pulse to the S-box clock-gating controller.
- sbox_si  out  4*(SEC_ORDER+1)  input shares, share i at bits [4i+3:4i].
- sbox_fresh  out  FRESH_W  Fresh bus to the S-box gadgets.
- sbox_so  in  4*(SEC_ORDER+1)  output shares from the S-box.
- sbox_synch  in  1  S-box result-ready strobe.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_shares  out  4*(SEC_ORDER+1)  captured output shares.
- out_data  out  4  XOR recombination of out_shares.
- err_timeout  out  1  sticky flag: Synch was not seen within TIMEOUT cycles.

Behaviour:
- Reset (rst=1 at a clk edge): state IDLE; in_ready=1; out_valid=0; err_timeout=0; sbox_rst=1; sbox_si, out_shares, out_data and counters all zero. A reset mid-operation aborts the transaction and the result is discarded.
- FSM states: IDLE, START, WAIT, CAPTURE, HOLD.
- IDLE:
  - in_ready=1; sbox_rst=0.
  - On in_valid&in_ready, register the shares: s1..sd = rnd[4*SEC_ORDER-1:0] slices, s0 = in_data ^ s1 ^ ... ^ sd.
  - Go to START.
- START:
  - sbox_rst=1 for exactly one cycle; clear the wait counter.
  - Go to WAIT.
- WAIT:
  - sbox_si is held constant for the whole transaction.
  - sbox_fresh = rnd[upper FRESH_W bits], passed through every cycle. The gadgets need fresh values per cycle, so it is never registered.
  - The counter increments each cycle.
  - On sbox_synch=1, go to CAPTURE. The S-box output register updates on the gated edge coincident with Synch.
  - If the counter reaches TIMEOUT with no Synch, set err_timeout, return to IDLE, and produce no output.
- CAPTURE:
  - Register out_shares <= sbox_so and out_data <= XOR of all shares.
  - Go to HOLD.
- HOLD:
  - out_valid=1; out_shares and out_data stay stable while out_valid=1 and out_ready=0.
  - On out_ready, drop out_valid and go to IDLE. in_ready returns to 1 on the next cycle (no input/output overlap).
- in_ready=0 in all states except IDLE.
- sbox_synch is ignored outside WAIT.
- Nominal latency: with the S-box Synch 9 cycles after START, out_valid rises 11 cycles after the accept edge.
- A Synch on the same cycle the counter reaches TIMEOUT counts as success; no error is flagged.
- err_timeout is cleared only by rst.
- out_data is the only unmasked result. Shares are never combined anywhere else; recombination is isolated in the output stage.

Decomposition:
- Shared package sbox_drv_pkg holds:
  - the state enum;
  - localparams SHARES=SEC_ORDER+1 and MASK_W=4*SEC_ORDER;
  - the FRESH_W formula;
  - the Skinny S-box constant table, for the bench reference model.
- One natural sub-module: share_split (combinational nibble masking, parameterised by SEC_ORDER), reused for output recombination checks.

Test Plan:
- Reset, then in_data=0x0 with rnd all zero -> out_valid rises 11 cycles after the accept edge; out_data=0xC; out_shares={0,0,0,0xC}.
- Sweep in_data 0x0..0xF with random rnd -> out_data matches {C,6,9,0,1,A,2,B,3,8,5,D,4,E,7,F}. The XOR of out_shares equals out_data, and sbox_si's XOR equals in_data.
- Hold out_ready=0 for 20 cycles after out_valid -> outputs stable; in_ready=0; a second in_valid is not accepted. Release -> in_ready=1 on the next cycle.
- Tie sbox_synch=0 -> err_timeout=1 exactly TIMEOUT(32) cycles after entering WAIT; FSM back in IDLE; no out_valid. A subsequent good transaction succeeds with err_timeout still 1.
- Assert rst in WAIT -> next cycle in_ready=1, out_valid=0, sbox_rst=1. A late Synch produces no output.
- Check sbox_rst is high for exactly 1 cycle per transaction, and sbox_fresh equals the upper rnd bits in the same cycle throughout WAIT.
